z3_slave_cycle: RTL
===================

# z3_slave_cycle

Zorro III slave-cycle front end for the A4092 CPLD. It synchronises the raw bus strobes and latches the multiplexed address and direction at the start of each cycle. It decodes the cycle against the configured 16 MB board base and drives `slave_cycle`, `ADDR`, `READ` and the synchronised `FCS_n` into the register, SID and SCSI decoders. It also merges their per-target acknowledges into the single `DTACK` output, with a watchdog so no cycle can hang the bus.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the strobe synchronisers. The address/READ pipeline uses the same depth.
- `TIMEOUT_CYCLES`, default 64: number of CLK cycles in `WAIT_ACK` before the block forces a termination.
- `NUM_ACK`, default 4: number of acknowledge sources merged.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: asynchronous, active-high reset.
- `FCS_RAW_n` in 1: Zorro III full cycle strobe, asynchronous to CLK.
- `DS_RAW_n` in 4: data strobes, asynchronous.
- `AD` in 32: multiplexed address/data bus. Address bits `[31:8]` are valid while `FCS_RAW_n` falls.
- `A_LO` in 6: address bits `[7:2]`.
- `READ_RAW` in 1: bus direction, 1 = read.
- `configured` in 1: Autoconfig is complete.
- `base` in 8: assigned base address `A[31:24]`.
- `ack_in` in `NUM_ACK`: per-target acknowledge pulses/levels. These are the SID, register and SCSI dtack sources.
- `FCS_n` out 1: synchronised FCS.
- `DS_n` out 4: synchronised data strobes.
- `ADDR` out 28: latched `A[27:0]`. `A[1:0]` is 0.
- `READ` out 1: latched direction.
- `slave_cycle` out 1: the current cycle targets this board.
- `DTACK` out 1: terminate the cycle, active high. The pad logic inverts it.
- `timeout_err` out 1: sticky flag, set when the watchdog fires.

## Operation
- **Synchroniser and sample pipeline.** `FCS_RAW_n` and `DS_RAW_n` pass through `SYNC_STAGES` flip-flops. `AD[31:8]`, `A_LO` and `READ_RAW` are registered through an equal-depth pipeline. The sample that leaves the pipeline is therefore the one taken in the same cycle as the strobe edge it is paired with.
- **State machine:**
  - `IDLE`: on a synchronised `FCS_n` falling edge, latch `ADDR` and `READ` from the pipeline output. If `configured && AD[31:24]==base`, go to `WAIT_ACK` and set `slave_cycle`. Otherwise go to `FOREIGN`.
  - `FOREIGN`: `slave_cycle` stays 0. Return to `IDLE` when `FCS_n` goes high.
  - `WAIT_ACK`: the watchdog counter increments.
    - Any `ack_in` bit high: go to `ACK` and set `DTACK` to 1.
    - Counter reaches `TIMEOUT_CYCLES-1`: go to `ACK`, set `DTACK` to 1 and set `timeout_err`.
    - `FCS_n` goes high (bus abort): go to `IDLE`, clear `slave_cycle`, and do not assert `DTACK`.
  - `ACK`: hold `DTACK` at 1 until `FCS_n` goes high. Then clear `DTACK` and `slave_cycle` in the same cycle and go to `IDLE`. Further `ack_in` activity in this state is ignored.
- **Latched outputs.** `ADDR` and `READ` hold their values until the next latch, including through `IDLE`.
- **Address rules.**
  - `ADDR[27:8]` = `AD[27:8]`, `ADDR[7:2]` = `A_LO`, and `ADDR[1:0]` = 0.
  - The base comparison uses `AD[31:24]` only.
- **Watchdog.** The counter width is `clog2(TIMEOUT_CYCLES)`. It clears on entry to `WAIT_ACK` and never wraps.
- **`timeout_err`.** It clears only on reset.
- **`configured` falling mid-cycle.** The cycle in progress completes normally. The check is made at latch time only.

## Timing
- **Reset values.** `FCS_n`=1, `DS_n`=4'hF, `ADDR`=0, `READ`=0, `slave_cycle`=0, `DTACK`=0, `timeout_err`=0, state `IDLE`. All synchroniser flops reset to 1 on strobes and to 0 on data.
- **Address latency.** `slave_cycle` and `ADDR` are valid `SYNC_STAGES`+1 CLK edges after the `FCS_RAW_n` fall.
- **Acknowledge latency.** `DTACK` rises one edge after the first `ack_in` high seen in `WAIT_ACK`.
- **Release latency.** `DTACK` falls one edge after the synchronised `FCS_n` is seen high, i.e. `SYNC_STAGES`+1 edges after `FCS_RAW_n` rises.
- **Simultaneous events in `WAIT_ACK`.** If `ack_in` and the timeout occur on the same edge, the acknowledge wins and `timeout_err` is not set. If `FCS_n` goes high together with `ack_in`, the abort wins.
- **Back-to-back cycles.** A new `FCS_n` fall one cycle after the return to `IDLE` is accepted.
- **Reset mid-cycle.** All outputs go immediately to their reset values. Decoding resumes on the next synchronised `FCS_n` falling edge, after the strobes have been seen high.

## Structure
- **Shared package `a4092_pkg`:**
  - the state enum (`IDLE`, `FOREIGN`, `WAIT_ACK`, `ACK`);
  - the `ack_in` bit index constants `ACK_SID`, `ACK_REG`, `ACK_SCSI`, `ACK_ROM`;
  - the address-field constant `Z3_BAR_MSB`=31.
- **Sub-module `strobe_sync`.** One parameterised N-stage synchroniser. It is instantiated for `FCS_RAW_n` and `DS_RAW_n` and reused for the matched data pipeline.

## Test plan
- `base`=0x40, configured, read at `AD`=0x408C0000 → `slave_cycle`=1, `ADDR`=0x08C0000, `READ`=1. Assert `ack_in[ACK_SID]` 3 cycles later → `DTACK` rises 1 edge later and falls `SYNC_STAGES`+1 edges after `FCS_RAW_n` rises.
- Write at `AD`=0x50000000 with `base`=0x40 → `slave_cycle` stays 0 and `DTACK` never asserts. Same address with `base`=0x50 but `configured`=0 → no response.
- No acknowledge with `TIMEOUT_CYCLES`=64 → `DTACK` asserts on the 64th `WAIT_ACK` cycle and `timeout_err`=1. The flag stays set through the next good cycle.
- `FCS_RAW_n` deasserted during `WAIT_ACK` before any acknowledge → return to `IDLE` and `DTACK` never asserts. The next cycle, at 0x40000004, decodes with `ADDR`=0x0000004.
- `ack_in` and timeout on the same edge → `DTACK`=1 and `timeout_err`=0. `RESET` pulsed while in `ACK` → `DTACK`=0 and `slave_cycle`=0 immediately, with all other outputs at their reset values.
- Two back-to-back cycles to 0x40800000 (write) then 0x408C0000 (read), separated by a single idle cycle → both are latched correctly and each gets exactly one `DTACK` pulse.

Source files
------------

// File: rtl/a4092_pkg.sv
// a4092_pkg: definitions shared by the A4092 Zorro III slave-cycle blocks.
//   - z3_state_e  : slave-cycle sequencer states
//   - ACK_*       : bit positions of the per-target acknowledges in ack_in
//   - Z3_BAR_MSB  : top address bit of the 16 MB board-base field
//   - z3_sample_t : address/direction sample carried through the matched pipeline
//   - z3_addr()   : forms the 28-bit board-relative address from a sample
package a4092_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FOREIGN  = 2'd1,
    WAIT_ACK = 2'd2,
    ACK      = 2'd3
  } z3_state_e;

  localparam int ACK_SID  = 0;
  localparam int ACK_REG  = 1;
  localparam int ACK_SCSI = 2;
  localparam int ACK_ROM  = 3;

  localparam int Z3_BAR_MSB = 31;

  // One address-phase sample: AD[31:8], A[7:2] and the direction bit.
  typedef struct packed {
    logic [Z3_BAR_MSB:8] ad_hi;
    logic [5:0]          a_lo;
    logic                read;
  } z3_sample_t;

  // Board-relative longword address; A[1:0] are always zero on Zorro III.
  function automatic logic [27:0] z3_addr(input z3_sample_t s);
    return {s.ad_hi[27:8], s.a_lo, 2'b00};
  endfunction

endpackage

// File: rtl/z3_slave_cycle_if.sv
// z3_slave_cycle_if: Zorro III bus-side signals seen by the slave-cycle front end.
//   FCS_RAW_n  full cycle strobe, asynchronous, active low
//   DS_RAW_n   data strobes [3:0], asynchronous, active low
//   AD         multiplexed address/data; A[31:8] valid while FCS_RAW_n falls
//   A_LO       address bits A[7:2]
//   READ_RAW   bus direction, 1 = read
//   DTACK      cycle termination, active high (inverted at the pad)
// Modports: master drives the strobes/address, slave returns DTACK.
interface z3_slave_cycle_if;

  logic        FCS_RAW_n;
  logic [3:0]  DS_RAW_n;
  logic [31:0] AD;
  logic [5:0]  A_LO;
  logic        READ_RAW;
  logic        DTACK;

  modport master (
    output FCS_RAW_n, DS_RAW_n, AD, A_LO, READ_RAW,
    input  DTACK
  );

  modport slave (
    input  FCS_RAW_n, DS_RAW_n, AD, A_LO, READ_RAW,
    output DTACK
  );

endinterface

// File: rtl/strobe_sync.sv
// strobe_sync: STAGES-deep register chain, WIDTH bits wide.
// Used both as a metastability synchroniser for asynchronous strobes and as
// the equal-depth delay line that keeps the address sample aligned with them.
//   clk       clock
//   rst       asynchronous, active-high reset; every stage loads RESET_VAL
//   d_in      input bits
//   q_out     output of the last stage
module strobe_sync #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d_in;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so every stage samples its
  // predecessor's old value; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_out = stage_q[STAGES-1];

endmodule

// File: rtl/z3_slave_cycle.sv
// z3_slave_cycle: Zorro III slave-cycle front end.
// Synchronises FCS/DS, latches address and direction at the start of each
// cycle, decodes against the 16 MB board base and merges the target
// acknowledges into DTACK, with a watchdog that terminates hung cycles.
//   CLK, RESET   clock and asynchronous active-high reset
//   bus          Zorro III strobes/address in, DTACK out (slave modport)
//   configured   Autoconfig complete
//   base         assigned base address A[31:24]
//   ack_in       per-target acknowledges (see ACK_* in a4092_pkg)
//   FCS_n, DS_n  synchronised strobes for the downstream decoders
//   ADDR, READ   latched A[27:0] and direction, held until the next cycle
//   slave_cycle  current cycle belongs to this board
//   timeout_err  sticky: the watchdog has terminated a cycle
module z3_slave_cycle
  import a4092_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NUM_ACK        = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  z3_slave_cycle_if.slave    bus,
  input  logic               configured,
  input  logic [7:0]         base,
  input  logic [NUM_ACK-1:0] ack_in,
  output logic               FCS_n,
  output logic [3:0]         DS_n,
  output logic [27:0]        ADDR,
  output logic               READ,
  output logic               slave_cycle,
  output logic               timeout_err
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam int SAMPLE_W = $bits(z3_sample_t);

  // ---------------------------------------------------------------------
  // Synchronisers and matched address pipeline
  // ---------------------------------------------------------------------
  logic       fcs_sync;
  logic [3:0] ds_sync;
  logic       sync_valid;
  z3_sample_t pipe;
  z3_sample_t sample_in;

  assign sample_in = '{ad_hi: bus.AD[Z3_BAR_MSB:8], a_lo: bus.A_LO, read: bus.READ_RAW};

  // A[7:0] of AD carry data only; the low address comes from A_LO.
  logic unused_ad_lo;
  assign unused_ad_lo = ^bus.AD[7:0];

  strobe_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_fcs_sync (
    .clk   (CLK),
    .rst   (RESET),
    .d_in  (bus.FCS_RAW_n),
    .q_out (fcs_sync)
  );

  strobe_sync #(.WIDTH(4), .STAGES(SYNC_STAGES), .RESET_VAL(4'hF)) u_ds_sync (
    .clk   (CLK),
    .rst   (RESET),
    .d_in  (bus.DS_RAW_n),
    .q_out (ds_sync)
  );

  strobe_sync #(.WIDTH(SAMPLE_W), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_addr_pipe (
    .clk   (CLK),
    .rst   (RESET),
    .d_in  (sample_in),
    .q_out (pipe)
  );

  // Goes high once the FCS chain holds real bus samples rather than its
  // reset value, so a strobe still low after reset is not taken as a fall.
  strobe_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_valid_sync (
    .clk   (CLK),
    .rst   (RESET),
    .d_in  (1'b1),
    .q_out (sync_valid)
  );

  // ---------------------------------------------------------------------
  // Cycle sequencer
  // ---------------------------------------------------------------------
  z3_state_e       state_q, state_d;
  logic            fcs_high_q, fcs_high_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [27:0]     addr_q, addr_d;
  logic            read_q, read_d;
  logic            slave_q, slave_d;
  logic            dtack_q, dtack_d;
  logic            terr_q, terr_d;

  logic fcs_fall;
  logic bar_hit;
  logic any_ack;

  // fcs_high_q: last cycle's synchronised FCS was a genuine high sample.
  assign fcs_fall = fcs_high_q & ~fcs_sync;
  assign bar_hit  = configured && (pipe.ad_hi[Z3_BAR_MSB -: 8] == base);
  assign any_ack  = |ack_in;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    fcs_high_d = sync_valid & fcs_sync;
    wd_cnt_d   = wd_cnt_q;
    addr_d     = addr_q;
    read_d     = read_q;
    slave_d    = slave_q;
    dtack_d    = dtack_q;
    terr_d     = terr_q;

    unique case (state_q)
      IDLE: begin
        if (fcs_fall) begin
          addr_d = z3_addr(pipe);
          read_d = pipe.read;
          if (bar_hit) begin
            state_d  = WAIT_ACK;
            slave_d  = 1'b1;
            wd_cnt_d = '0;
          end else begin
            state_d = FOREIGN;
          end
        end
      end

      FOREIGN: begin
        if (fcs_sync) begin
          state_d = IDLE;
        end
      end

      // Priority: bus abort, then target acknowledge, then watchdog.
      WAIT_ACK: begin
        if (fcs_sync) begin
          state_d = IDLE;
          slave_d = 1'b0;
        end else if (any_ack) begin
          state_d = ACK;
          dtack_d = 1'b1;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = ACK;
          dtack_d = 1'b1;
          terr_d  = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end

      ACK: begin
        if (fcs_sync) begin
          state_d = IDLE;
          dtack_d = 1'b0;
          slave_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      fcs_high_q <= 1'b0;
      wd_cnt_q   <= '0;
      addr_q     <= '0;
      read_q     <= 1'b0;
      slave_q    <= 1'b0;
      dtack_q    <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcs_high_q <= fcs_high_d;
      wd_cnt_q   <= wd_cnt_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      slave_q    <= slave_d;
      dtack_q    <= dtack_d;
      terr_q     <= terr_d;
    end
  end

  assign FCS_n       = fcs_sync;
  assign DS_n        = ds_sync;
  assign ADDR        = addr_q;
  assign READ        = read_q;
  assign slave_cycle = slave_q;
  assign timeout_err = terr_q;
  assign bus.DTACK   = dtack_q;

endmodule
